// File: rtl/spi_load_ctrl_pkg.sv
// spi_load_ctrl shared definitions: command opcodes, FSM states, word size.
// Optional macro SPI_LOAD_CKSUM_EN adds the CKSUM state.
package spi_load_ctrl_pkg;

   localparam logic [7:0] CMD_WRITE_IMEM = 8'h01;
   localparam logic [7:0] CMD_READ_DMEM  = 8'h02;
   localparam logic [7:0] CMD_RUN        = 8'h03;
   localparam logic [7:0] CMD_HALT       = 8'h04;

   localparam int WORD_BYTES = 4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_WDATA,
      ST_RDREQ,
      ST_RDWAIT,
      ST_RDSEND,
`ifdef SPI_LOAD_CKSUM_EN
      ST_CKSUM,
`endif
      ST_DISCARD
   } state_e;

endpackage

// File: rtl/spi_word_shift.sv
// spi_word_shift: 32-bit byte shift register, MSB first in or out,
// with a byte counter.
// Ports: clk, rst (sync, active high), clr_i (zero byte counter),
//   load_i/load_data_i (parallel load), shift_in_i/byte_i (shift a
//   byte in at the bottom), shift_out_i (shift top byte out),
//   word_o (register contents), last_o (current byte is the last one).
module spi_word_shift
   import spi_load_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        load_i,
   input  logic [31:0] load_data_i,
   input  logic        shift_in_i,
   input  logic [7:0]  byte_i,
   input  logic        shift_out_i,
   output logic [31:0] word_o,
   output logic        last_o
);

   logic [31:0] word_q;
   logic [1:0]  cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (clr_i) begin
         cnt_q  <= '0;
      end else if (load_i) begin
         word_q <= load_data_i;
         cnt_q  <= '0;
      end else if (shift_in_i) begin
         word_q <= {word_q[23:0], byte_i};
         cnt_q  <= cnt_q + 2'd1;
      end else if (shift_out_i) begin
         word_q <= {word_q[23:0], 8'h00};
         cnt_q  <= cnt_q + 2'd1;
      end
   end

   assign word_o = word_q;
   assign last_o = (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/spi_load_ctrl.sv
// spi_load_ctrl: SPI byte-command sequencer that loads IMEM, reads DMEM
// and owns core_halt.
// Ports: clk, rst (sync, active high); frame_active, rx_valid, rx_data
//   from the SPI slave; tx_ready/tx_valid/tx_data toward it; imem_we,
//   imem_addr, imem_wdata (IMEM port B); dmem_addr, dmem_rdata (DMEM
//   port B); core_halt, busy, err status.
// Optional macro SPI_LOAD_CKSUM_EN: WRITE_IMEM ends with an XOR byte.
module spi_load_ctrl
   import spi_load_ctrl_pkg::*;
#(
   parameter bit BOOT_HALTED = 1'b1,
   parameter int LEN_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_active,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic [31:0] dmem_addr,
   input  logic [31:0] dmem_rdata,
   output logic        core_halt,
   output logic        busy,
   output logic        err
);

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              wr_q, wr_d;
   logic              halt_q, halt_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       iaddr_q, iaddr_d;
`ifdef SPI_LOAD_CKSUM_EN
   logic [7:0]        cksum_q, cksum_d;
`endif

   logic        byte_ev;
   logic        in_payload;
   logic        sh_in, sh_out, sh_load;
   logic [31:0] sh_word;
   logic        sh_last;

   assign byte_ev = rx_valid & frame_active;

   // Losing the frame here means data was half-moved.
   assign in_payload = (state_q == ST_WDATA)
                     | (state_q == ST_RDREQ)
                     | (state_q == ST_RDWAIT)
`ifdef SPI_LOAD_CKSUM_EN
                     | (state_q == ST_CKSUM)
`endif
                     | (state_q == ST_RDSEND);

   spi_word_shift u_shift (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (~frame_active),
      .load_i      (sh_load),
      .load_data_i (dmem_rdata),
      .shift_in_i  (sh_in),
      .byte_i      (rx_data),
      .shift_out_i (sh_out),
      .word_o      (sh_word),
      .last_o      (sh_last)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      wr_d    = wr_q;
      halt_d  = halt_q;
      err_d   = err_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      iaddr_d = iaddr_q;
      sh_in   = 1'b0;
      sh_out  = 1'b0;
      sh_load = 1'b0;
`ifdef SPI_LOAD_CKSUM_EN
      cksum_d = cksum_q;
`endif
      if (!frame_active) begin
         if (in_payload) err_d = 1'b1;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (byte_ev) begin
                  case (rx_data)
                     CMD_WRITE_IMEM: begin
                        if (halt_q) begin
                           wr_d    = 1'b1;
                           state_d = ST_ADDR;
                        end else begin
                           err_d   = 1'b1;
                           state_d = ST_DISCARD;
                        end
                     end
                     CMD_READ_DMEM: begin
                        wr_d    = 1'b0;
                        state_d = ST_ADDR;
                     end
                     CMD_RUN:  halt_d = 1'b0;
                     CMD_HALT: begin
                        halt_d = 1'b1;
                        err_d  = 1'b0;
                     end
                     default: begin
                        err_d   = 1'b1;
                        state_d = ST_DISCARD;
                     end
                  endcase
               end
            end
            ST_ADDR: begin
               if (byte_ev) begin
                  sh_in = 1'b1;
                  if (sh_last) begin
                     addr_d  = {sh_word[23:0], rx_data[7:2], 2'b00};
                     state_d = ST_LEN;
                  end
               end
            end
            ST_LEN: begin
               if (byte_ev) begin
                  // 0 wraps on the first decrement: 2**LEN_W words.
                  len_d   = LEN_W'(rx_data);
                  state_d = wr_q ? ST_WDATA : ST_RDREQ;
`ifdef SPI_LOAD_CKSUM_EN
                  cksum_d = 8'h00;
`endif
               end
            end
            ST_WDATA: begin
               if (byte_ev) begin
                  sh_in = 1'b1;
`ifdef SPI_LOAD_CKSUM_EN
                  cksum_d = cksum_q ^ rx_data;
`endif
                  if (sh_last) begin
                     we_d    = 1'b1;
                     wdata_d = {sh_word[23:0], rx_data};
                     iaddr_d = addr_q;
                     addr_d  = addr_q + 32'(WORD_BYTES);
                     if (len_q == LEN_W'(1)) begin
`ifdef SPI_LOAD_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_IDLE;
`endif
                     end else begin
                        len_d = len_q - LEN_W'(1);
                     end
                  end
               end
            end
            ST_RDREQ:  state_d = ST_RDWAIT;
            ST_RDWAIT: begin
               sh_load = 1'b1;
               state_d = ST_RDSEND;
            end
            ST_RDSEND: begin
               if (tx_ready) begin
                  sh_out = 1'b1;
                  if (sh_last) begin
                     addr_d = addr_q + 32'(WORD_BYTES);
                     if (len_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                     end else begin
                        len_d   = len_q - LEN_W'(1);
                        state_d = ST_RDREQ;
                     end
                  end
               end
            end
`ifdef SPI_LOAD_CKSUM_EN
            ST_CKSUM: begin
               if (byte_ev) begin
                  if (rx_data != cksum_q) err_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
`endif
            ST_DISCARD: state_d = ST_DISCARD;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         wr_q    <= 1'b0;
         halt_q  <= BOOT_HALTED;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         iaddr_q <= '0;
`ifdef SPI_LOAD_CKSUM_EN
         cksum_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         iaddr_q <= iaddr_d;
`ifdef SPI_LOAD_CKSUM_EN
         cksum_q <= cksum_d;
`endif
      end
   end

   assign tx_valid   = (state_q == ST_RDSEND);
   assign tx_data    = tx_valid ? sh_word[31:24] : 8'h00;
   assign imem_we    = we_q;
   assign imem_addr  = iaddr_q;
   assign imem_wdata = wdata_q;
   assign dmem_addr  = addr_q;
   assign core_halt  = halt_q;
   assign busy       = (state_q != ST_IDLE);
   assign err        = err_q;

endmodule

// File: tb/tb_spi_load_ctrl.sv
// Scoreboard bench for spi_load_ctrl: expected IMEM writes and TX bytes
// are queued by the stimulus and popped by independent monitors.
module tb_spi_load_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_active;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_rdata = 32'h0;
   logic        core_halt;
   logic        busy;
   logic        err;

   int checks = 0;
   int passes = 0;

   logic [63:0] wq[$];
   logic [7:0]  txq[$];
   logic [7:0]  ck;

   spi_load_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .frame_active (frame_active),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .tx_ready     (tx_ready),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .dmem_addr    (dmem_addr),
      .dmem_rdata   (dmem_rdata),
      .core_halt    (core_halt),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   // Synchronous-read DMEM with one known word.
   always @(posedge clk)
      dmem_rdata <= (dmem_addr == 32'h20) ? 32'hCAFEF00D : 32'h0;

   initial begin
      tx_ready = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 tx_ready = ~tx_ready;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // IMEM write monitor.
   initial forever begin
      @(negedge clk);
      if (imem_we) begin
         if (wq.size() == 0) begin
            chk("imem_we_unexpected", 32'(imem_we), 32'h0);
         end else begin
            logic [63:0] e;
            e = wq.pop_front();
            chk("imem_addr", imem_addr, e[63:32]);
            chk("imem_wdata", imem_wdata, e[31:0]);
         end
      end
   end

   // TX byte monitor plus hold-until-ready check.
   initial begin
      logic       pend;
      logic [7:0] prev;
      pend = 1'b0;
      prev = 8'h00;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("tx_hold_valid", 32'(tx_valid), 32'h1);
            chk("tx_hold_data", 32'(tx_data), 32'(prev));
         end
         if (tx_valid && tx_ready) begin
            if (txq.size() == 0)
               chk("tx_unexpected", 32'(tx_valid), 32'h0);
            else
               chk("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
         end
         pend = tx_valid && !tx_ready;
         prev = tx_data;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // All tasks enter and leave at posedge + 1.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pay(input logic [7:0] b);
      ck = ck ^ b;
      send_byte(b);
   endtask

   task automatic send_cksum(input logic [7:0] b);
`ifdef SPI_LOAD_CKSUM_EN
      send_byte(b);
`else
      if (b != b) send_byte(b);
`endif
   endtask

   task automatic frame_start();
      frame_active = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic frame_end();
      frame_active = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("busy_idle", 32'(busy), 32'h0);
   endtask

   task automatic cmd_frame(input logic [7:0] c);
      frame_start();
      send_byte(c);
      frame_end();
   endtask

   initial begin
      rst          = 1'b1;
      frame_active = 1'b0;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      ck           = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_halt", 32'(core_halt), 32'h1);
      chk("rst_imem_we", 32'(imem_we), 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Two-word write, payload back to back.
      wq.push_back({32'h10, 32'hDEADBEEF});
      wq.push_back({32'h14, 32'h01234567});
      frame_start();
      send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h02);
      ck = 8'h00;
      send_pay(8'hDE); send_pay(8'hAD);
      send_pay(8'hBE); send_pay(8'hEF);
      send_pay(8'h01); send_pay(8'h23);
      send_pay(8'h45); send_pay(8'h67);
      send_cksum(8'h22);
      @(posedge clk); #1;
      chk("w1_busy", 32'(busy), 32'h0);
      chk("w1_err", 32'(err), 32'h0);
      frame_end();

      // Unaligned address forced down; address wraps past 2**32.
      wq.push_back({32'hFFFFFFFC, 32'h0BADC0DE});
      wq.push_back({32'h00000000, 32'h13572468});
      frame_start();
      send_byte(8'h01);
      send_byte(8'hFF); send_byte(8'hFF);
      send_byte(8'hFF); send_byte(8'hFE);
      send_byte(8'h02);
      ck = 8'h00;
      send_pay(8'h0B); send_pay(8'hAD);
      send_pay(8'hC0); send_pay(8'hDE);
      repeat (2) @(posedge clk);
      #1;
      send_pay(8'h13); send_pay(8'h57);
      send_pay(8'h24); send_pay(8'h68);
      send_cksum(ck);
      @(posedge clk); #1;
      chk("w2_busy", 32'(busy), 32'h0);
      frame_end();

      // DMEM read with throttled tx_ready.
      txq.push_back(8'hCA);
      txq.push_back(8'hFE);
      txq.push_back(8'hF0);
      txq.push_back(8'h0D);
      frame_start();
      send_byte(8'h02);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h01);
      wait_idle();
      chk("rd_txq_empty", 32'(txq.size()), 32'h0);
      frame_end();

      // RUN, then WRITE_IMEM is refused.
      cmd_frame(8'h03);
      chk("run_core_halt", 32'(core_halt), 32'h0);
      frame_start();
      send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22);
      send_byte(8'h33); send_byte(8'h44);
      chk("wrun_busy_discard", 32'(busy), 32'h1);
      frame_end();
      chk("wrun_err", 32'(err), 32'h1);
      chk("wrun_core_halt", 32'(core_halt), 32'h0);
      chk("wrun_busy", 32'(busy), 32'h0);
      cmd_frame(8'h04);
      chk("halt_core_halt", 32'(core_halt), 32'h1);
      chk("halt_err", 32'(err), 32'h0);

      // Frame dropped mid-payload.
      frame_start();
      send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'hBB);
      frame_active = 1'b0;
      @(posedge clk); #1;
      chk("drop_busy", 32'(busy), 32'h0);
      chk("drop_err", 32'(err), 32'h1);
      chk("drop_core_halt", 32'(core_halt), 32'h1);
      chk("drop_imem_we", 32'(imem_we), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      cmd_frame(8'h04);
      chk("drop_clr_err", 32'(err), 32'h0);

      // Unknown opcode.
      cmd_frame(8'h55);
      chk("unk_err", 32'(err), 32'h1);
      chk("unk_busy", 32'(busy), 32'h0);
      cmd_frame(8'h04);

`ifdef SPI_LOAD_CKSUM_EN
      wq.push_back({32'h40, 32'h11223344});
      frame_start();
      send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h40);
      send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22);
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h44);
      frame_end();
      chk("ck_good_err", 32'(err), 32'h0);
      wq.push_back({32'h40, 32'h11223344});
      frame_start();
      send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h40);
      send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22);
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h45);
      frame_end();
      chk("ck_bad_err", 32'(err), 32'h1);
      cmd_frame(8'h04);
`endif

      // Reset mid-command restores the boot state.
      cmd_frame(8'h03);
      chk("run2_core_halt", 32'(core_halt), 32'h0);
      frame_start();
      send_byte(8'h02);
      send_byte(8'h00);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_core_halt", 32'(core_halt), 32'h1);
      chk("mrst_busy", 32'(busy), 32'h0);
      rst          = 1'b0;
      frame_active = 1'b0;

      repeat (5) @(posedge clk);
      #1;
      chk("end_wq_empty", 32'(wq.size()), 32'h0);
      chk("end_txq_empty", 32'(txq.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
